mul_div_unit: RTL and testbench

//   Multi-cycle signed multiply/divide engine beside the ALU, feeding the 64-bit Z register.

---
 rtl/mul_div_unit.sv | 138 +++++++++++++
 tb/tb_mul_div_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (non-restoring) engine.
// Results are registered when the operation completes and held until the next accepted start.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t                  r_state, w_next;
  logic [CW-1:0]           r_cnt;
  logic signed [AW-1:0]    r_acc, r_m;
  logic [WIDTH-1:0]        r_q;
  logic                    r_qm1, r_neg_q, r_neg_r;

  logic                    w_accept, w_last, w_b_zero;
  logic signed [AW-1:0]    w_bsum, w_bacc, w_dsh, w_dsum;
  logic [WIDTH-1:0]        w_bq, w_dq, w_rem;

  function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_b_zero = (b == '0);

  // Booth step: add/sub multiplicand per {q0,q_-1}, then arithmetic shift of {acc,q}
  always_comb begin
    w_bsum = r_acc;
    case ({r_q[0], r_qm1})
      2'b01:   w_bsum = r_acc + r_m;
      2'b10:   w_bsum = r_acc - r_m;
      default: w_bsum = r_acc;
    endcase
    w_bacc = w_bsum >>> 1;
    w_bq   = {w_bsum[0], r_q[WIDTH-1:1]};
  end

  // Non-restoring step: partial remainder sign picks add or subtract of |b|
  assign w_dsh  = {r_acc[AW-2:0], r_q[WIDTH-1]};
  assign w_dsum = r_acc[AW-1] ? (w_dsh + r_m) : (w_dsh - r_m);
  assign w_dq   = {r_q[WIDTH-2:0], ~w_dsum[AW-1]};
  assign w_rem  = WIDTH'(r_acc[AW-1] ? (r_acc + r_m) : r_acc);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start)                w_next = !op ? S_MUL : (w_b_zero ? S_DONE : S_DIV);
        else                      w_next = S_IDLE;
      end
      S_MUL:   if (w_last) w_next = S_DONE;
      S_DIV:   if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt       <= '0;
      result_hi   <= '0;
      result_lo   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (w_accept)                                r_cnt <= '0;
      else if (r_state == S_MUL || r_state == S_DIV) r_cnt <= r_cnt + CW'(1);

      if (w_accept) begin
        div_by_zero <= op && w_b_zero;
        if (op && w_b_zero) begin
          result_hi <= a;
          result_lo <= '1;
        end
      end else if (r_state == S_MUL && w_last) begin
        result_hi <= w_bacc[WIDTH-1:0];
        result_lo <= w_bq;
      end else if (r_state == S_FIX) begin
        result_hi <= f_neg(w_rem, r_neg_r);
        result_lo <= f_neg(r_q, r_neg_q);
      end
    end
  end

  // Datapath registers carry no reset; they are always loaded on an accepted start
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_acc <= '0;
      r_qm1 <= 1'b0;
      if (!op) begin
        r_m <= {{2{a[WIDTH-1]}}, a};
        r_q <= b;
      end else begin
        r_m     <= {2'b00, f_abs(b)};
        r_q     <= f_abs(a);
        r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
        r_neg_r <= a[WIDTH-1];
      end
    end else if (r_state == S_MUL) begin
      r_acc <= w_bacc;
      r_q   <= w_bq;
      r_qm1 <= r_q[0];
    end else if (r_state == S_DIV) begin
      r_acc <= w_dsum;
      r_q   <= w_dq;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        clr, start, op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] result_hi, result_lo;

  int n_chk  = 0;
  int n_pass = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic ref_model(input logic o, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sx, sy, p, q, r;
    sx = $signed(x);
    sy = $signed(y);
    dz = 1'b0;
    if (!o) begin
      p  = sx * sy;
      hi = p[63:32];
      lo = p[31:0];
    end else if (y == 0) begin
      dz = 1'b1;
      hi = x;
      lo = 32'hFFFF_FFFF;
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      hi = r[31:0];
      lo = q[31:0];
    end
  endtask

  // Called just after a falling edge; returns just after the accepting rising edge
  task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input int exp_k, input bit poke);
    int got_k;
    got_k = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (poke && k == 9) begin
        start = 1'b1; op = 1'b1; a = 32'd5; b = 32'd0;
      end else begin
        start = 1'b0;
      end
      if (k == 0) begin
        check("busy_k0", 64'(busy), 64'(exp_k > 0));
        check("dbz_k0", 64'(div_by_zero), 64'(exp_k == 0));
      end
      if (done) begin
        got_k = k;
        break;
      end
    end
    check("latency", 64'(got_k), 64'(exp_k));
  endtask

  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y, input bit poke);
    logic [31:0] ehi, elo;
    logic        edz;
    int          lat;
    ref_model(o, x, y, ehi, elo, edz);
    lat = !o ? 33 : (y == 0 ? 1 : 34);
    issue(o, x, y);
    wait_done(lat - 1, poke);
    check("result", {result_hi, result_lo}, {ehi, elo});
    check("dbz", 64'(div_by_zero), 64'(edz));
  endtask

  task automatic idle_check();
    logic [63:0] held;
    held = {result_hi, result_lo};
    @(negedge clk);
    check("idle_ctl", {62'd0, busy, done}, 64'd0);
    check("hold", {result_hi, result_lo}, held);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    clr = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_ctl", {61'd0, busy, done, div_by_zero}, 64'd0);
    check("rst_res", {result_hi, result_lo}, 64'd0);
    clr = 1'b1;
    @(negedge clk);

    run_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
    idle_check();
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    idle_check();
    run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    run_op(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle_check();
    run_op(1'b1, 32'd5, 32'd0, 1'b0);
    idle_check();
    run_op(1'b0, 32'd3, 32'd4, 1'b0);

    // start during a multiply is ignored, then back-to-back from DONE
    idle_check();
    run_op(1'b0, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
    run_op(1'b1, 32'hDEAD_BEEF, 32'h0000_0123, 1'b0);
    idle_check();

    // asynchronous reset in the middle of a divide
    issue(1'b1, 32'd1000, 32'd7);
    repeat (14) @(negedge clk);
    #2 clr = 1'b0;
    #1;
    check("clr_ctl", {61'd0, busy, done, div_by_zero}, 64'd0);
    check("clr_res", {result_hi, result_lo}, 64'd0);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) check("clr_nodone", 64'(done), 64'd0);
    end
    clr = 1'b1;
    @(negedge clk);
    run_op(1'b0, 32'd6, 32'd7, 1'b0);
    idle_check();

    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom), pick(), pick(), 1'b0);
      if ($urandom_range(0, 1) == 1) idle_check();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
